// File: rtl/eightbit_divider_ctrl.sv
// Sequential 8-bit unsigned restoring divider built around one ripple-borrow subtractor.
// Runs eight iterations under a start/busy/done handshake and flags divide-by-zero up front.

module eightbit_subtractor (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       cout,
  output logic       overflow
);
  // a - b as a + ~b + 1; carry out high means no borrow (a >= b)
  logic [8:0] carry;
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign diff[gi]      = a[gi] ^ ~b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & ~b[gi]) | (carry[gi] & (a[gi] ^ ~b[gi]));
    end
  endgenerate

  assign cout     = carry[8];
  assign overflow = carry[8] ^ carry[7];
endmodule

module eightbit_divider_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg;
  logic [7:0] r_reg;
  logic [7:0] q_reg;
  logic [7:0] d_reg;
  logic [2:0] cnt_reg;
  logic [7:0] quotient_reg;
  logic [7:0] remainder_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       dbz_reg;

  logic [7:0] shift_next;
  logic [7:0] r_iter_next;
  logic [7:0] q_iter_next;
  logic [7:0] sub_diff;
  logic       sub_cout;
  logic       sub_overflow_unused;
  logic       r_msb_unused;

  // The partial remainder never exceeds 127 before a shift, so its MSB is shifted out unused.
  assign r_msb_unused = r_reg[7];

  eightbit_subtractor u_sub (
    .a        (shift_next),
    .b        (d_reg),
    .diff     (sub_diff),
    .cout     (sub_cout),
    .overflow (sub_overflow_unused)
  );

  always_comb begin
    shift_next  = {r_reg[6:0], q_reg[7]};
    r_iter_next = sub_cout ? sub_diff : shift_next;
    q_iter_next = {q_reg[6:0], sub_cout};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      r_reg         <= 8'd0;
      q_reg         <= 8'd0;
      d_reg         <= 8'd0;
      cnt_reg       <= 3'd0;
      quotient_reg  <= 8'd0;
      remainder_reg <= 8'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          if (start) begin
            q_reg   <= dividend;
            d_reg   <= divisor;
            r_reg   <= 8'd0;
            cnt_reg <= 3'd0;
            if (divisor == 8'd0) begin
              // No iterations needed: report saturated quotient immediately
              state_reg     <= DONE;
              done_reg      <= 1'b1;
              quotient_reg  <= 8'hFF;
              remainder_reg <= dividend;
              dbz_reg       <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_reg   <= r_iter_next;
          q_reg   <= q_iter_next;
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            quotient_reg  <= q_iter_next;
            remainder_reg <= r_iter_next;
            dbz_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
endmodule
